// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode 0 initiator issuing 16-bit register frames
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  input  logic       cipo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q;
  // In SHIFT: index of the next sclk edge (odd = fall). In GAP: half of the gap done.
  logic [4:0]  edge_q;
  logic [15:0] tx_q;
  logic [7:0]  rx_q;
  logic        sclk_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        div_wrap;

  assign div_wrap  = (div_q == DIV_LAST);
  assign sclk      = sclk_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each phase ends when the half-period counter wraps
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_SETUP;
      S_SETUP: if (div_wrap) state_d = S_SHIFT;
      S_SHIFT: if (div_wrap && edge_q == 5'd31) state_d = S_HOLD;
      S_HOLD:  if (div_wrap) state_d = S_GAP;
      S_GAP:   if (div_wrap && edge_q[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; copi is forced low whenever the peripheral is deselected
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    ncs       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        ncs       = 1'b1;
      end
      S_GAP:   ncs = 1'b1;
      default: ncs = 1'b0;
    endcase
    copi = ncs ? 1'b0 : tx_q[15];
  end

  // Datapath: counters, sclk generation, tx/rx shifting and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 8'd0;
      edge_q      <= 5'd0;
      tx_q        <= 16'd0;
      rx_q        <= 8'd0;
      sclk_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
    end else begin
      rsp_valid_q <= (state_q == S_HOLD) && div_wrap;
      if ((state_q == S_HOLD) && div_wrap) begin
        rsp_rdata_q <= rx_q;
      end

      if (state_q == S_IDLE) begin
        div_q <= 8'd0;
      end else begin
        div_q <= div_wrap ? 8'd0 : div_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          edge_q <= 5'd0;
          sclk_q <= 1'b0;
          if (req_valid) begin
            tx_q <= {req_rw, req_addr, req_wdata};
          end
        end
        S_SETUP: begin
          if (div_wrap) begin
            // Rise 0: sample first rx bit, next edge is fall 0
            sclk_q <= 1'b1;
            edge_q <= 5'd1;
            rx_q   <= {rx_q[6:0], cipo};
          end
        end
        S_SHIFT: begin
          if (div_wrap) begin
            sclk_q <= ~edge_q[0];
            edge_q <= (edge_q == 5'd31) ? 5'd0 : edge_q + 5'd1;
            if (edge_q[0]) begin
              // Falls 0..14 advance copi; after fall 15 copi keeps bit 0
              if (edge_q != 5'd31) begin
                tx_q <= {tx_q[14:0], 1'b0};
              end
            end else begin
              rx_q <= {rx_q[6:0], cipo};
            end
          end
        end
        S_HOLD: begin
          sclk_q <= 1'b0;
        end
        S_GAP: begin
          // Gap is two half-periods so the 8-bit divider never has to count to 2*CLK_DIV
          if (div_wrap) begin
            edge_q <= edge_q[0] ? 5'd0 : 5'd1;
          end
        end
        default: begin
          sclk_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
